// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: parity modes, FSM states, line idle level.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; also used by the transmitter queue.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees the head slot this edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable width/parity/divisor, sticky error flags and an output FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 2604,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RX,
    input  logic                          clr_rdy,
    input  logic                          clr_err,
    output logic                          rdy,
    output logic [DATA_W-1:0]             cmd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);

    logic              rx_m, rx_s;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              parb_q, parb_d;
    logic              push_q, push_d;
    logic              tick, par_bad, ferr_set, perr_set, ovr_set;
    logic              full, empty, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= IDLE_LVL;
            rx_s <= IDLE_LVL;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    assign tick = (cnt_q == '0);
    // Odd parity expects the XOR of data and parity bit to be 1, even expects 0.
    assign par_bad = (PARITY != PAR_NONE) &&
                     ((^data_q ^ parb_q) != (PARITY == PAR_ODD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            parb_q  <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            parb_q  <= parb_d;
            push_q  <= push_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        parb_d   = parb_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        if (state_q != ST_IDLE && !tick) cnt_d = cnt_q - CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (rx_s != IDLE_LVL) begin
                    state_d = ST_START;
                    cnt_d   = HALF_BIT;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s == IDLE_LVL) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = FULL_BIT;
                        idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    data_d[idx_q] = rx_s;
                    cnt_d         = FULL_BIT;
                    if (idx_q == IDX_W'(DATA_W - 1))
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    else
                        idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    parb_d  = rx_s;
                    cnt_d   = FULL_BIT;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Return to IDLE on the sample itself so a start bit in the last half bit is caught.
                if (tick) begin
                    state_d = ST_IDLE;
                    if (rx_s != IDLE_LVL) ferr_set = 1'b1;
                    else if (par_bad)     perr_set = 1'b1;
                    else                  push_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rdy     = ~empty;
    assign pop     = clr_rdy & ~empty;
    assign ovr_set = push_q & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= ferr_set | (frame_err  & ~clr_err);
            parity_err <= perr_set | (parity_err & ~clr_err);
            overrun    <= ovr_set  | (overrun    & ~clr_err);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (clr_rdy),
        .wdata (data_q),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt),
        .head  (cmd)
    );
endmodule
